// File: rtl/riscv_pkg.sv
// Shared load-path types: load func3 encodings, load opcode and the data-memory FSM states.
package riscv_pkg;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } load_f3_e;

    localparam logic [6:0] OPCODE_LOAD = 7'b0000011;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } dmem_state_t;

endpackage

// File: rtl/load_align_ext.sv
// Combinational byte/half/word extraction with sign/zero extension for loads.
// With DMEM_MISALIGN_CHECK_EN defined, also flags misaligned or unsupported loads and forces data to zero.
module load_align_ext
    import riscv_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] word_i,
    input  logic [1:0]        off_i,
    input  logic [2:0]        func3_i,
`ifdef DMEM_MISALIGN_CHECK_EN
    output logic              misalign_o,
`endif
    output logic [DATA_W-1:0] data_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic        err;

    always_comb begin
        byte_v = word_i[{off_i, 3'b000} +: 8];
        half_v = off_i[1] ? word_i[31:16] : word_i[15:0];
        data_o = word_i;
        err    = 1'b0;
        case (func3_i)
            LB:  data_o = {{24{byte_v[7]}}, byte_v};
            LBU: data_o = {24'b0, byte_v};
            LH:  begin data_o = {{16{half_v[15]}}, half_v}; err = off_i[0]; end
            LHU: begin data_o = {16'b0, half_v};            err = off_i[0]; end
            LW:  err = (off_i != 2'b00);
            default: err = 1'b1;
        endcase
`ifdef DMEM_MISALIGN_CHECK_EN
        if (err) data_o = '0;
`endif
    end

`ifdef DMEM_MISALIGN_CHECK_EN
    assign misalign_o = err;
`else
    logic unused_err;
    assign unused_err = err;
`endif

endmodule

// File: rtl/dmem_load_unit.sv
// Multi-cycle data-memory load responder: IDLE -> ACCESS (LATENCY cycles) -> RESP, word RAM with preload port.
// Optional misalign/unsupported-func3 error reporting under DMEM_MISALIGN_CHECK_EN.
module dmem_load_unit
    import riscv_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     dmem_read_en,
    input  logic [ADDR_W-1:0]        addr,
    input  logic [2:0]               func3,
    input  logic                     init_we,
    input  logic [$clog2(DEPTH)-1:0] init_addr,
    input  logic [DATA_W-1:0]        init_wdata,
    output logic                     busy,
    output logic                     load_valid,
`ifdef DMEM_MISALIGN_CHECK_EN
    output logic                     misalign_err,
`endif
    output logic [DATA_W-1:0]        load_data
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    dmem_state_t       state_q;
    logic [CW-1:0]     cnt_q;
    logic [2:0]        func3_q;
    logic [1:0]        off_q;
    logic [DATA_W-1:0] word_q;
    logic              load_valid_q;
    logic [DATA_W-1:0] load_data_q;
    logic [DATA_W-1:0] ext_data;
    logic [IW-1:0]     word_idx;

    // Bits above the word index wrap the address modulo DEPTH words.
    assign word_idx = addr[IW+1:2];
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[ADDR_W-1:IW+2];

    // Preload port has no reset and writes in any state; a same-cycle accept sees the old word.
    always_ff @(posedge clk) begin
        if (init_we) mem_q[init_addr] <= init_wdata;
    end

`ifdef DMEM_MISALIGN_CHECK_EN
    logic ext_err;
    logic misalign_q;

    load_align_ext #(.DATA_W(DATA_W)) u_align (
        .word_i     (word_q),
        .off_i      (off_q),
        .func3_i    (func3_q),
        .misalign_o (ext_err),
        .data_o     (ext_data)
    );

    always_ff @(posedge clk) begin
        if (rst)                                        misalign_q <= 1'b0;
        else if (state_q == ACCESS && cnt_q == '0)      misalign_q <= ext_err;
        else                                            misalign_q <= 1'b0;
    end

    assign misalign_err = misalign_q;
`else
    load_align_ext #(.DATA_W(DATA_W)) u_align (
        .word_i  (word_q),
        .off_i   (off_q),
        .func3_i (func3_q),
        .data_o  (ext_data)
    );
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            func3_q      <= '0;
            off_q        <= '0;
            word_q       <= '0;
            load_valid_q <= 1'b0;
            load_data_q  <= '0;
        end else begin
            load_valid_q <= 1'b0;
            case (state_q)
                IDLE: if (dmem_read_en) begin
                    func3_q <= func3;
                    off_q   <= addr[1:0];
                    word_q  <= mem_q[word_idx];
                    cnt_q   <= CW'(LATENCY - 1);
                    state_q <= ACCESS;
                end
                ACCESS: if (cnt_q == '0) begin
                    state_q      <= RESP;
                    load_valid_q <= 1'b1;
                    load_data_q  <= ext_data;
                end else begin
                    cnt_q <= cnt_q - 1'b1;
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy       = (state_q != IDLE);
    assign load_valid = load_valid_q;
    assign load_data  = load_data_q;

endmodule

// File: tb/tb_dmem_load_unit.sv
// Self-checking bench for dmem_load_unit: reset, directed table, handshake timing, collision/abort, random loads.
// Build with DMEM_MISALIGN_CHECK_EN defined to exercise the error-reporting variant.
module tb_dmem_load_unit;

    localparam int LAT   = 2;
    localparam int DEPTH = 256;
    localparam int P     = LAT + 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        dmem_read_en;
    logic [31:0] addr;
    logic [2:0]  func3;
    logic        init_we;
    logic [7:0]  init_addr;
    logic [31:0] init_wdata;
    logic        busy;
    logic        load_valid;
    logic [31:0] load_data;
`ifdef DMEM_MISALIGN_CHECK_EN
    logic        misalign_err;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] ref_mem [DEPTH];

    always #5 clk = ~clk;

    dmem_load_unit #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk          (clk),
        .rst          (rst),
        .dmem_read_en (dmem_read_en),
        .addr         (addr),
        .func3        (func3),
        .init_we      (init_we),
        .init_addr    (init_addr),
        .init_wdata   (init_wdata),
        .busy         (busy),
        .load_valid   (load_valid),
`ifdef DMEM_MISALIGN_CHECK_EN
        .misalign_err (misalign_err),
`endif
        .load_data    (load_data)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Reference from the load rules: arithmetic byte/half selection and two's-complement extension.
    function automatic void ref_load(input logic [31:0] w, input logic [1:0] o, input logic [2:0] f,
                                     output logic [31:0] d, output logic e);
        logic [31:0] b, h;
        b = (w >> (8 * o)) % 256;
        h = (w >> (16 * (o / 2))) % 65536;
        e = 1'b0;
        case (f)
            3'd0:    d = (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'd1:    d = (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'd4:    d = b;
            3'd5:    d = h;
            default: d = w;
        endcase
`ifdef DMEM_MISALIGN_CHECK_EN
        if (((f == 3'd1 || f == 3'd5) && o % 2 == 1) || (f == 3'd2 && o != 0) ||
            !(f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) begin
            e = 1'b1;
            d = 32'h0;
        end
`endif
    endfunction

    task automatic preload(input logic [7:0] idx, input logic [31:0] data);
        init_we    = 1'b1;
        init_addr  = idx;
        init_wdata = data;
        ref_mem[idx] = data;
        @(negedge clk);
        init_we = 1'b0;
    endtask

    // Issue one load from a negedge, return result, error and cycle offset of load_valid.
    task automatic do_load(input logic [31:0] a, input logic [2:0] f,
                           output logic [31:0] d, output logic e, output int k);
        int w = 0;
        while (busy && w < 20) begin @(negedge clk); w++; end
        dmem_read_en = 1'b1;
        addr  = a;
        func3 = f;
        @(negedge clk);
        dmem_read_en = 1'b0;
        init_we = 1'b0;
        k = 1;
        while (!load_valid && k < 20) begin @(negedge clk); k++; end
        d = load_data;
`ifdef DMEM_MISALIGN_CHECK_EN
        e = misalign_err;
`else
        e = 1'b0;
`endif
    endtask

    typedef struct {
        string       nm;
        logic [31:0] a;
        logic [2:0]  f;
        logic [31:0] exp_d;
        logic        exp_e;
    } vec_t;

    initial begin
        vec_t        vecs[$];
        logic [31:0] d, ed;
        logic        e, ee;
        int          k, nv;

        rst = 1'b1; dmem_read_en = 1'b1; addr = '0; func3 = 3'b010;
        init_we = 1'b0; init_addr = '0; init_wdata = '0;

        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("reset_busy", {31'b0, busy}, 32'h0);
            chk("reset_valid", {31'b0, load_valid}, 32'h0);
            chk("reset_data", load_data, 32'h0);
`ifdef DMEM_MISALIGN_CHECK_EN
            chk("reset_err", {31'b0, misalign_err}, 32'h0);
`endif
        end
        rst = 1'b0; dmem_read_en = 1'b0;

        for (int i = 0; i < DEPTH; i++) preload(8'(i), $urandom);
        preload(8'd0, 32'h8000_7F81);
        preload(8'd5, 32'h1234_5678);

        vecs.push_back('{"lb0",  32'd0, 3'b000, 32'hFFFF_FF81, 1'b0});
        vecs.push_back('{"lbu0", 32'd0, 3'b100, 32'h0000_0081, 1'b0});
        vecs.push_back('{"lb1",  32'd1, 3'b000, 32'h0000_007F, 1'b0});
        vecs.push_back('{"lb3",  32'd3, 3'b000, 32'hFFFF_FF80, 1'b0});
        vecs.push_back('{"lh2",  32'd2, 3'b001, 32'hFFFF_8000, 1'b0});
        vecs.push_back('{"lhu2", 32'd2, 3'b101, 32'h0000_8000, 1'b0});
        vecs.push_back('{"lh0",  32'd0, 3'b001, 32'h0000_7F81, 1'b0});
        vecs.push_back('{"lw0",  32'd0, 3'b010, 32'h8000_7F81, 1'b0});
        vecs.push_back('{"wrap", 32'h0000_0414, 3'b010, 32'h1234_5678, 1'b0});
`ifdef DMEM_MISALIGN_CHECK_EN
        vecs.push_back('{"lw2_mis",  32'd2, 3'b010, 32'h0, 1'b1});
        vecs.push_back('{"lh3_mis",  32'd3, 3'b001, 32'h0, 1'b1});
        vecs.push_back('{"f3_011",   32'd0, 3'b011, 32'h0, 1'b1});
`else
        vecs.push_back('{"lw2_noc",  32'd2, 3'b010, 32'h8000_7F81, 1'b0});
        vecs.push_back('{"lh3_noc",  32'd3, 3'b001, 32'hFFFF_8000, 1'b0});
        vecs.push_back('{"f3_011",   32'd0, 3'b011, 32'h8000_7F81, 1'b0});
`endif

        foreach (vecs[i]) begin
            do_load(vecs[i].a, vecs[i].f, d, e, k);
            chk({vecs[i].nm, "_data"}, d, vecs[i].exp_d);
            chk({vecs[i].nm, "_lat"}, k, LAT + 1);
`ifdef DMEM_MISALIGN_CHECK_EN
            chk({vecs[i].nm, "_err"}, {31'b0, e}, {31'b0, vecs[i].exp_e});
`endif
        end

        // Continuous request: one response every LAT+2 cycles, busy low only on the accept cycle.
        @(negedge clk);
        chk("hs_idle", {31'b0, busy}, 32'h0);
        dmem_read_en = 1'b1; addr = 32'd0; func3 = 3'b010;
        nv = 0;
        for (int c = 1; c <= 3 * P; c++) begin
            @(negedge clk);
            if (c == 3 * P) dmem_read_en = 1'b0;
            chk($sformatf("hs_valid_c%0d", c), {31'b0, load_valid}, {31'b0, (c % P) == (P - 1)});
            chk($sformatf("hs_busy_c%0d", c), {31'b0, busy}, {31'b0, (c % P) != 0});
            if (load_valid) begin
                nv++;
                chk("hs_data", load_data, 32'h8000_7F81);
            end
        end
        chk("hs_count", nv, 3);

        // Preload write to the word being read in the same cycle: old contents come back.
        preload(8'd3, 32'h0);
        init_we = 1'b1; init_addr = 8'd3; init_wdata = 32'hDEAD_BEEF;
        do_load(32'd12, 3'b010, d, e, k);
        ref_mem[3] = 32'hDEAD_BEEF;
        chk("collide_old", d, 32'h0);
        chk("collide_lat", k, LAT + 1);
        @(negedge clk);
        do_load(32'd12, 3'b010, d, e, k);
        chk("collide_new", d, 32'hDEAD_BEEF);

        // Reset during ACCESS aborts the load.
        @(negedge clk);
        dmem_read_en = 1'b1; addr = 32'd0; func3 = 3'b010;
        @(negedge clk);
        dmem_read_en = 1'b0;
        chk("abort_busy_pre", {31'b0, busy}, 32'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy_post", {31'b0, busy}, 32'h0);
        chk("abort_data", load_data, 32'h0);
        nv = 0;
        for (int c = 0; c < 2 * P; c++) begin
            @(negedge clk);
            if (load_valid) nv++;
        end
        chk("abort_no_valid", nv, 0);

        // Random loads against the reference, with occasional preload writes in between.
        for (int i = 0; i < 150; i++) begin
            logic [31:0] ra;
            logic [2:0]  rf;
            if ($urandom_range(0, 3) == 0) preload(8'($urandom_range(0, DEPTH - 1)), $urandom);
            ra = $urandom;
            rf = 3'($urandom_range(0, 7));
            ref_load(ref_mem[ra[9:2]], ra[1:0], rf, ed, ee);
            do_load(ra, rf, d, e, k);
            chk($sformatf("rnd%0d_a%h_f%0d_data", i, ra, rf), d, ed);
            chk($sformatf("rnd%0d_lat", i), k, LAT + 1);
`ifdef DMEM_MISALIGN_CHECK_EN
            chk($sformatf("rnd%0d_err", i), {31'b0, e}, {31'b0, ee});
`else
            if (ee) n_bad += 0;
`endif
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
